cnn_window_gen: RTL and testbench
=================================

Name: cnn_window_gen

Overview:
- Streaming sliding-window generator; the producer that feeds the CNN kernel compute block.
- Accepts one input-fmap pixel per valid cycle in raster order (row-major, top-left first).
- Emits each complete KX*KY window, packed in the kernel's i_in_fmap layout, with a valid strobe.
- Stride 1, no padding; one frame of IX*IY pixels yields (IX-KX+1)*(IY-KY+1) windows.

Parameters:
- KX, 3, kernel width in pixels; 2 <= KX <= IX.
- KY, 3, kernel height in pixels; 2 <= KY <= IY.
- I_F_BW, 8, bit width of one fmap pixel.
- IX, 8, frame width in pixels.
- IY, 8, frame height in pixels.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_soft_reset  input  1  synchronous clear; same effect as reset, applied on the clock edge.
- i_in_valid  input  1  i_in_pixel is valid this cycle and is consumed (no backpressure).
- i_in_pixel  input  I_F_BW  input pixel.
- o_ot_valid  output  1  o_ot_fmap holds a complete window (one-cycle strobe per window).
- o_ot_fmap  output  KX*KY*I_F_BW  window; element i = ky*KX+kx sits at [i*I_F_BW +: I_F_BW]. ky=0 is the top (oldest) row; kx=0 is the left (oldest) column.
- o_frame_done  output  1  one-cycle pulse after the last window of a frame.

Behaviour:
- Storage:
  - KY-1 line buffers, each IX pixels deep; contents are not reset.
  - A KX*KY window shift register.
  - col counter, 0..IX-1, and row counter, 0..IY-1.
- On each accepted pixel:
  - Window columns shift left by one.
  - The new right column takes the line-buffer taps (oldest row at ky=0) plus i_in_pixel at ky=KY-1.
  - Line buffers update for the current col.
  - col increments; it wraps to 0 at IX-1 and row increments.
- Cycles with i_in_valid=0: all state holds and o_ot_valid=0. Gaps of any length are legal.
- FSM states:
  - IDLE: col=row=0. The first accepted pixel moves to FILL, or to RUN if KY-1 rows are already satisfied (never true for KY>=2).
  - FILL: rows 0..KY-2 are loading and no windows are emitted. Move to RUN when the pixel at (KY-2, IX-1) is accepted.
  - RUN: for the pixel at (r,c), o_ot_valid=1 on the next cycle iff c>=KX-1. That window covers rows r-KY+1..r and cols c-KX+1..c. Move to DONE when the pixel at (IY-1, IX-1) is accepted.
  - DONE: one cycle; o_frame_done=1 in the cycle after the final window's o_ot_valid; counters are zero; go to IDLE.
- Latency: exactly 1 cycle from the accepted pixel completing a window to o_ot_valid.
- Outputs are registered. o_ot_fmap updates only on emitted windows and holds otherwise.
- A pixel arriving while in DONE is accepted as pixel (0,0) of the next frame. o_frame_done still pulses, and the FSM goes to FILL.
- Row-wrap boundary: window columns spanning a row boundary must never be emitted (c<KX-1 guard). Stale columns from the previous row are flushed by the KX-1 shifts before the first emission of each row.
- Reset and i_soft_reset (either one, including mid-frame):
  - o_ot_valid=0, o_frame_done=0, o_ot_fmap=0.
  - Counters=0, state=IDLE.
  - Line-buffer and window contents are don't-care, since they are refilled before any emission.
  - i_soft_reset has priority over i_in_valid in the same cycle; that pixel is dropped.
- Counter widths are clog2(IX) and clog2(IY), minimum 1 bit.

Optional Feature:
- Macro: CNN_WIN_POS_EN.
- Defined: adds output ports o_ot_ox [clog2(IX-KX+1)] and o_ot_oy [clog2(IY-KY+1)]. Each holds the output-map coordinate of the window (c-KX+1, r-KY+1). They are registered alongside o_ot_fmap and reset to 0.
- Undefined: the ports and their registers do not exist; all other behaviour is identical.

Test Plan (IX=IY=4, KX=KY=3, I_F_BW=8; pixel at (r,c) = 4r+c+1; valid every cycle):
- Full frame of 16 pixels -> exactly 4 o_ot_valid pulses.
  - First pulse one cycle after pixel 11: elements 0..8 = 1,2,3,5,6,7,9,10,11.
  - Last pulse: 6,7,8,10,11,12,14,15,16.
  - o_frame_done pulses the cycle after the last window.
- Same frame with i_in_valid toggled 1/0 each cycle -> identical 4 windows in the same order, each exactly 1 cycle after its completing pixel; o_ot_valid is never high in gap cycles.
- Two back-to-back frames, second = first + 16 -> 8 windows total. The second frame's first window is 17,18,19,21,22,23,25,26,27 (no cross-frame contamination).
- Reset asserted after pixel 9, then a full fresh frame -> outputs go to 0 asynchronously; exactly 4 correct windows follow, with the first equal to 1,2,3,5,6,7,9,10,11.
- i_soft_reset concurrent with i_in_valid on pixel 7, then a full frame -> pixel 7 is dropped; the fresh frame yields the same 4 windows as scenario 1.
- With CNN_WIN_POS_EN, scenario 1 -> (ox,oy) = (0,0),(1,0),(0,1),(1,1) on the 4 pulses.

Source files
------------

// File: rtl/cnn_window_gen_if.sv
// cnn_window_gen_if
//    Pixel-stream in / window-stream out bundle for cnn_window_gen.
//    Optional macro: CNN_WIN_POS_EN adds the window output-map coordinates.
//
//    Signals:
//       i_in_valid    pixel strobe (no backpressure)
//       i_in_pixel    one fmap pixel, I_F_BW bits
//       o_ot_valid    one-cycle strobe per complete window
//       o_ot_fmap     packed window, FMAP_W = KX*KY*I_F_BW bits
//       o_frame_done  one-cycle pulse after the last window of a frame
//       o_ot_ox/oy    window coordinate in the output map (CNN_WIN_POS_EN only)
//
//    Modports:
//       master  pixel producer / window consumer side
//       slave   the window generator itself

interface cnn_window_gen_if #(
   parameter int I_F_BW = 8,
   parameter int FMAP_W = 72
`ifdef CNN_WIN_POS_EN
   ,
   parameter int OX_W = 1,
   parameter int OY_W = 1
`endif
);

   logic              i_in_valid;
   logic [I_F_BW-1:0] i_in_pixel;
   logic              o_ot_valid;
   logic [FMAP_W-1:0] o_ot_fmap;
   logic              o_frame_done;

`ifdef CNN_WIN_POS_EN
   logic [OX_W-1:0]   o_ot_ox;
   logic [OY_W-1:0]   o_ot_oy;

   modport master (
      output i_in_valid, i_in_pixel,
      input  o_ot_valid, o_ot_fmap, o_frame_done, o_ot_ox, o_ot_oy
   );

   modport slave (
      input  i_in_valid, i_in_pixel,
      output o_ot_valid, o_ot_fmap, o_frame_done, o_ot_ox, o_ot_oy
   );
`else
   modport master (
      output i_in_valid, i_in_pixel,
      input  o_ot_valid, o_ot_fmap, o_frame_done
   );

   modport slave (
      input  i_in_valid, i_in_pixel,
      output o_ot_valid, o_ot_fmap, o_frame_done
   );
`endif

endinterface

// File: rtl/cnn_window_gen.sv
// cnn_window_gen
//    Streaming stride-1, no-padding sliding-window generator. Takes one
//    IX*IY frame in raster order and emits every KX*KY window, packed so
//    that element ky*KX+kx sits at [(ky*KX+kx)*I_F_BW +: I_F_BW], with
//    ky=0 the oldest row and kx=0 the oldest column.
//    Optional macro: CNN_WIN_POS_EN adds registered window coordinates.
//
//    Ports:
//       clk           rising-edge clock
//       reset         asynchronous active-high reset
//       i_soft_reset  synchronous clear, wins over a same-cycle pixel
//       bus           cnn_window_gen_if slave modport (pixel in, window out)

module cnn_window_gen #(
   parameter int KX     = 3,
   parameter int KY     = 3,
   parameter int I_F_BW = 8,
   parameter int IX     = 8,
   parameter int IY     = 8
) (
   input logic             clk,
   input logic             reset,
   input logic             i_soft_reset,
   cnn_window_gen_if.slave bus
);

   localparam int COL_W  = (IX > 1) ? $clog2(IX) : 1;
   localparam int ROW_W  = (IY > 1) ? $clog2(IY) : 1;
   localparam int FMAP_W = KX * KY * I_F_BW;

   localparam logic [COL_W-1:0] COL_LAST       = COL_W'(IX - 1);
   localparam logic [ROW_W-1:0] ROW_LAST       = ROW_W'(IY - 1);
   localparam logic [ROW_W-1:0] FILL_LAST_ROW  = ROW_W'(KY - 2);
   localparam logic [COL_W-1:0] FIRST_EMIT_COL = COL_W'(KX - 1);

`ifdef CNN_WIN_POS_EN
   localparam int OX_W = ((IX - KX + 1) > 1) ? $clog2(IX - KX + 1) : 1;
   localparam int OY_W = ((IY - KY + 1) > 1) ? $clog2(IY - KY + 1) : 1;
   localparam logic [ROW_W-1:0] FIRST_EMIT_ROW = ROW_W'(KY - 1);
`endif

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN,
      DONE
   } state_t;

   state_t            state;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;

   // line_buf[0] holds the oldest buffered row; line_buf[KY-2] the row just above the current one
   logic [I_F_BW-1:0] line_buf [KY-1][IX];
   logic [I_F_BW-1:0] win      [KY][KX];
   logic [I_F_BW-1:0] win_next [KY][KX];
   logic [FMAP_W-1:0] fmap_next;

   logic accept;
   logic emit;

   // A pixel is taken whenever valid, unless the soft clear drops it.
   // Windows come out only in RUN and only once KX columns of the current
   // row exist, which keeps row-straddling windows from ever being emitted.
   always_comb begin
      accept = bus.i_in_valid && !i_soft_reset;
      emit   = accept && (state == RUN) && (col >= FIRST_EMIT_COL);
   end

   // Next window: shift every row left by one and load the new right column
   // from the line-buffer taps at the current column plus the incoming pixel.
   always_comb begin
      win_next = win;
      for (int ky = 0; ky < KY; ky++) begin
         for (int kx = 0; kx < KX - 1; kx++) begin
            win_next[ky][kx] = win[ky][kx+1];
         end
      end
      for (int ky = 0; ky < KY - 1; ky++) begin
         win_next[ky][KX-1] = line_buf[ky][col];
      end
      win_next[KY-1][KX-1] = bus.i_in_pixel;
   end

   // Flatten the next window into the kernel's packed layout.
   always_comb begin
      fmap_next = '0;
      for (int ky = 0; ky < KY; ky++) begin
         for (int kx = 0; kx < KX; kx++) begin
            fmap_next[(ky*KX+kx)*I_F_BW +: I_F_BW] = win_next[ky][kx];
         end
      end
   end

   // Line buffers and window storage carry no reset: everything they hold is
   // overwritten during the fill rows and the first KX-1 shifts of a row
   // before any window built from them can be emitted.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < KY - 2; k++) begin
            line_buf[k][col] <= line_buf[k+1][col];
         end
         line_buf[KY-2][col] <= bus.i_in_pixel;
         win <= win_next;
      end
   end

   // Control FSM with position counters and all registered outputs.
   // o_frame_done is raised on leaving DONE so it lands one cycle after the
   // final window strobe; a pixel accepted in DONE starts the next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         col              <= '0;
         row              <= '0;
         bus.o_ot_valid   <= 1'b0;
         bus.o_frame_done <= 1'b0;
         bus.o_ot_fmap    <= '0;
`ifdef CNN_WIN_POS_EN
         bus.o_ot_ox      <= '0;
         bus.o_ot_oy      <= '0;
`endif
      end else if (i_soft_reset) begin
         state            <= IDLE;
         col              <= '0;
         row              <= '0;
         bus.o_ot_valid   <= 1'b0;
         bus.o_frame_done <= 1'b0;
         bus.o_ot_fmap    <= '0;
`ifdef CNN_WIN_POS_EN
         bus.o_ot_ox      <= '0;
         bus.o_ot_oy      <= '0;
`endif
      end else begin
         bus.o_ot_valid   <= emit;
         bus.o_frame_done <= (state == DONE);

         if (emit) begin
            bus.o_ot_fmap <= fmap_next;
`ifdef CNN_WIN_POS_EN
            bus.o_ot_ox   <= OX_W'(col - FIRST_EMIT_COL);
            bus.o_ot_oy   <= OY_W'(row - FIRST_EMIT_ROW);
`endif
         end

         if (accept) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (accept) state <= FILL;
            end
            FILL: begin
               if (accept && (row == FILL_LAST_ROW) && (col == COL_LAST)) state <= RUN;
            end
            RUN: begin
               if (accept && (row == ROW_LAST) && (col == COL_LAST)) state <= DONE;
            end
            DONE: begin
               state <= accept ? FILL : IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen
//    Directed bench for cnn_window_gen at IX=IY=4, KX=KY=3, I_F_BW=8 with
//    pixel (r,c) = base + 4r + c + 1. Covers reset state, a full frame,
//    a gapped frame, back-to-back frames, async reset mid-frame and a
//    soft clear colliding with a pixel.
//    Optional macro: CNN_WIN_POS_EN also checks the window coordinates.

module tb_cnn_window_gen;

   localparam int KX     = 3;
   localparam int KY     = 3;
   localparam int I_F_BW = 8;
   localparam int IX     = 4;
   localparam int IY     = 4;
   localparam int FMAP_W = KX * KY * I_F_BW;

   localparam logic [FMAP_W-1:0] WIN_FIRST  = 72'h0B0A09070605030201;
   localparam logic [FMAP_W-1:0] WIN_LAST   = 72'h100F0E0C0B0A080706;
   localparam logic [FMAP_W-1:0] WIN_F2_FIRST = 72'h1B1A19171615131211;

   logic clk;
   logic reset;
   logic soft_reset;

   int checks;
   int errors;
   int wins;
   bit done_due;
   logic [FMAP_W-1:0] last_fmap;
   logic [FMAP_W-1:0] first_win;
   logic [FMAP_W-1:0] last_win;

`ifdef CNN_WIN_POS_EN
   int exp_ox;
   int exp_oy;
`endif

   cnn_window_gen_if #(
      .I_F_BW(I_F_BW),
      .FMAP_W(FMAP_W)
`ifdef CNN_WIN_POS_EN
      ,
      .OX_W(1),
      .OY_W(1)
`endif
   ) bus ();

   cnn_window_gen #(
      .KX(KX),
      .KY(KY),
      .I_F_BW(I_F_BW),
      .IX(IX),
      .IY(IY)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i_soft_reset(soft_reset),
      .bus(bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected window whose bottom-right pixel is (r,c) in a frame offset by base.
   function automatic logic [FMAP_W-1:0] win_exp(input int r, input int c, input int base);
      logic [FMAP_W-1:0] w;
      w = '0;
      for (int ky = 0; ky < KY; ky++) begin
         for (int kx = 0; kx < KX; kx++) begin
            w[(ky*KX+kx)*I_F_BW +: I_F_BW] = 8'(base + IX*(r-KY+1+ky) + (c-KX+1+kx) + 1);
         end
      end
      return w;
   endfunction

   // Drive one cycle of inputs at the falling edge, return just after the rising edge.
   task automatic apply_stimulus(input logic v, input logic [I_F_BW-1:0] pix, input logic sr);
      @(negedge clk);
      bus.i_in_valid = v;
      bus.i_in_pixel = pix;
      soft_reset     = sr;
      @(posedge clk);
      #1;
   endtask

   // Compare all outputs against expectations; fmap must equal the last expected window.
   task automatic check_output(input string tag, input logic exp_v, input logic [FMAP_W-1:0] exp_f);
      checks++;
      assert (bus.o_ot_valid === exp_v)
      else begin
         errors++;
         $error("[TB] FAIL %s valid: got %b want %b", tag, bus.o_ot_valid, exp_v);
      end
      checks++;
      assert (bus.o_frame_done === done_due)
      else begin
         errors++;
         $error("[TB] FAIL %s frame_done: got %b want %b", tag, bus.o_frame_done, done_due);
      end
      if (exp_v) last_fmap = exp_f;
      checks++;
      assert (bus.o_ot_fmap === last_fmap)
      else begin
         errors++;
         $error("[TB] FAIL %s fmap: got %h want %h", tag, bus.o_ot_fmap, last_fmap);
      end
`ifdef CNN_WIN_POS_EN
      if (exp_v) begin
         checks++;
         assert ((int'(bus.o_ot_ox) === exp_ox) && (int'(bus.o_ot_oy) === exp_oy))
         else begin
            errors++;
            $error("[TB] FAIL %s pos: got (%0d,%0d) want (%0d,%0d)", tag,
                   bus.o_ot_ox, bus.o_ot_oy, exp_ox, exp_oy);
         end
      end
`endif
      if (bus.o_ot_valid === 1'b1) begin
         wins++;
         if (wins == 1) first_win = bus.o_ot_fmap;
         last_win = bus.o_ot_fmap;
      end
      done_due = 1'b0;
   endtask

   // Stream one 16-pixel frame, optionally with an idle cycle after every pixel.
   task automatic run_frame(input string tag, input int base, input bit toggle);
      bit ev;
      wins = 0;
      for (int p = 0; p < IX*IY; p++) begin
         int r;
         int c;
         r  = p / IX;
         c  = p % IX;
         ev = (r >= KY-1) && (c >= KX-1);
`ifdef CNN_WIN_POS_EN
         exp_ox = c - (KX-1);
         exp_oy = r - (KY-1);
`endif
         apply_stimulus(1'b1, 8'(base + p + 1), 1'b0);
         check_output(tag, ev, win_exp(r, c, base));
         if (p == IX*IY-1) done_due = 1'b1;
         if (toggle) begin
            apply_stimulus(1'b0, 8'h00, 1'b0);
            check_output({tag, "_gap"}, 1'b0, '0);
         end
      end
   endtask

   task automatic check_value(input string tag, input logic [FMAP_W-1:0] got, input logic [FMAP_W-1:0] want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("[TB] FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic check_count(input string tag, input int got, input int want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("[TB] FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      wins           = 0;
      done_due       = 1'b0;
      last_fmap      = '0;
      first_win      = '0;
      last_win       = '0;
      reset          = 1'b1;
      soft_reset     = 1'b0;
      bus.i_in_valid = 1'b0;
      bus.i_in_pixel = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_state", 1'b0, '0);
      @(negedge clk);
      reset = 1'b0;

      // Scenario 1: full frame, valid every cycle
      $display("[TB] full frame");
      run_frame("full", 0, 1'b0);
      check_count("full_wins", wins, 4);
      check_value("full_first", first_win, WIN_FIRST);
      check_value("full_last", last_win, WIN_LAST);
      apply_stimulus(1'b0, 8'h00, 1'b0);
      check_output("full_done", 1'b0, '0);

      // Scenario 2: same frame with a gap after every pixel
      $display("[TB] gapped frame");
      run_frame("gap", 0, 1'b1);
      check_count("gap_wins", wins, 4);
      check_value("gap_first", first_win, WIN_FIRST);
      check_value("gap_last", last_win, WIN_LAST);

      // Scenario 3: two frames back to back, second offset by 16
      $display("[TB] back-to-back frames");
      run_frame("b2b_a", 0, 1'b0);
      check_count("b2b_a_wins", wins, 4);
      run_frame("b2b_b", 16, 1'b0);
      check_count("b2b_b_wins", wins, 4);
      check_value("b2b_b_first", first_win, WIN_F2_FIRST);
      apply_stimulus(1'b0, 8'h00, 1'b0);
      check_output("b2b_done", 1'b0, '0);

      // Scenario 4: async reset after pixel 9, then a fresh frame
      $display("[TB] async reset mid-frame");
      for (int p = 0; p < 9; p++) begin
         apply_stimulus(1'b1, 8'(p + 1), 1'b0);
         check_output("pre_reset", 1'b0, '0);
      end
      #2;
      reset          = 1'b1;
      bus.i_in_valid = 1'b0;
      #1;
      last_fmap = '0;
      check_output("async_reset", 1'b0, '0);
      @(negedge clk);
      reset = 1'b0;
      run_frame("post_reset", 0, 1'b0);
      check_count("post_reset_wins", wins, 4);
      check_value("post_reset_first", first_win, WIN_FIRST);
      apply_stimulus(1'b0, 8'h00, 1'b0);
      check_output("post_reset_done", 1'b0, '0);

      // Scenario 5: soft reset collides with pixel 7, then a fresh frame
      $display("[TB] soft reset with pixel");
      for (int p = 0; p < 6; p++) begin
         apply_stimulus(1'b1, 8'(p + 1), 1'b0);
         check_output("pre_soft", 1'b0, '0);
      end
      apply_stimulus(1'b1, 8'd7, 1'b1);
      last_fmap = '0;
      check_output("soft_reset", 1'b0, '0);
      run_frame("post_soft", 0, 1'b0);
      check_count("post_soft_wins", wins, 4);
      check_value("post_soft_first", first_win, WIN_FIRST);
      check_value("post_soft_last", last_win, WIN_LAST);
      apply_stimulus(1'b0, 8'h00, 1'b0);
      check_output("post_soft_done", 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
